// File: rtl/ahb_app_pkg.sv
// Shared types and helpers for the AHB application-port arbiter.
// Also used by the AHB master's testbench for size decoding.
package ahb_app_pkg;

  typedef enum logic [1:0] {
    ARB,
    ISSUE,
    DRAIN
  } arb_state_e;

  localparam int OP_NEW   = 4;
  localparam int OP_INCR  = 3;
  localparam int OP_WRITE = 2;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_UART = 2'd3;

  function automatic logic [2:0] bytes_of(input logic [1:0] size);
    unique case (size)
      SZ_BYTE, SZ_UART: return 3'd1;
      SZ_HALF:          return 3'd2;
      default:          return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Request arbiter: round-robin by default, fixed lowest-index priority
// when ARB_FIXED_PRIO_EN is defined.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic [N-1:0]  req,
  input  logic          adv,
  input  logic [IW-1:0] adv_idx,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

`ifdef ARB_FIXED_PRIO_EN
  logic unused;
  assign unused = ^{HCLK, HRESETn, adv, adv_idx};

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        gnt     = '0;
        gnt[i]  = 1'b1;
        gnt_idx = IW'(i);
      end
    end
  end
`else
  logic [IW-1:0] ptr_q;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ptr_q <= '0;
    end else if (adv) begin
      ptr_q <= (adv_idx == IW'(N - 1)) ? '0 : adv_idx + IW'(1);
    end
  end

  // Scan from the far end so the smallest offset from ptr_q wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[(int'(ptr_q) + i) % N]) begin
        gnt                           = '0;
        gnt[(int'(ptr_q) + i) % N]    = 1'b1;
        gnt_idx                       = IW'((int'(ptr_q) + i) % N);
      end
    end
  end
`endif

endmodule

// File: rtl/ahb_app_arbiter.sv
// Shares one AHB-Lite master app port among NUM_REQ requesters,
// sequencing bursts beat by beat. ARB_FIXED_PRIO_EN selects fixed priority.
module ahb_app_arbiter
  import ahb_app_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [2*NUM_REQ-1:0]      req_size,
  input  logic [5*NUM_REQ-1:0]      req_beats,
  input  logic [ADDR_W*NUM_REQ-1:0] req_addr,
  input  logic [DATA_W*NUM_REQ-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ack,
  output logic [NUM_REQ-1:0]        wdata_pop,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [NUM_REQ-1:0]        rsp_done,
  output logic [NUM_REQ-1:0]        rsp_error,
  output logic [4:0]                m_opcode,
  output logic [ADDR_W-1:0]         m_addr,
  output logic [DATA_W-1:0]         m_data_in,
  output logic                      m_enable,
  output logic                      m_busy,
  input  logic [DATA_W-1:0]         m_data_out,
  input  logic                      m_data_valid,
  input  logic                      m_error,
  input  logic                      m_wait
);

  localparam int IW = $clog2(NUM_REQ);

  arb_state_e         state_q, state_d;
  logic [IW-1:0]      g_q, win_idx;
  logic [NUM_REQ-1:0] win, sel;
  logic [4:0]         beats_q, issue_cnt, rsp_cnt, beats_in;
  logic [ADDR_W-1:0]  addr_q;
  logic [1:0]         size_q;
  logic               write_q, first_q;
  logic               grant, step, count, fin;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .req     (req_valid),
    .adv     (fin),
    .adv_idx (g_q),
    .gnt     (win),
    .gnt_idx (win_idx)
  );

  assign beats_in = (req_beats[int'(win_idx)*5 +: 5] == 5'd0) ?
                    5'd1 : req_beats[int'(win_idx)*5 +: 5];
  assign sel      = NUM_REQ'(1) << g_q;
  assign m_busy   = 1'b0;

  always_comb begin
    state_d   = state_q;
    req_ack   = '0;
    wdata_pop = '0;
    rsp_valid = '0;
    rsp_done  = '0;
    rsp_error = '0;
    rsp_rdata = '0;
    m_opcode  = '0;
    m_addr    = '0;
    m_data_in = '0;
    m_enable  = 1'b0;
    grant     = 1'b0;
    step      = 1'b0;
    count     = 1'b0;
    fin       = 1'b0;
    unique case (state_q)
      ARB: begin
        // Gate on reset so no ack escapes while HRESETn is low.
        if (HRESETn && |req_valid) begin
          grant   = 1'b1;
          req_ack = win;
          state_d = ISSUE;
        end
      end
      ISSUE, DRAIN: begin
        m_enable  = 1'b1;
        rsp_valid = sel & {NUM_REQ{m_data_valid}};
        rsp_rdata = m_data_out;
        count     = write_q ? !m_wait : m_data_valid;
        if (state_q == ISSUE) begin
          m_addr             = addr_q;
          m_data_in          = req_wdata[int'(g_q)*DATA_W +: DATA_W];
          m_opcode[OP_NEW]   = first_q;
          m_opcode[OP_INCR]  = beats_q > 5'd1;
          m_opcode[OP_WRITE] = write_q;
          m_opcode[1:0]      = size_q;
          step               = !m_wait && !m_error;
          if (step && write_q) wdata_pop = sel;
          if (step && issue_cnt == 5'd1) state_d = DRAIN;
        end else if (rsp_cnt == beats_q) begin
          fin      = 1'b1;
          rsp_done = sel;
          state_d  = ARB;
        end
        if (m_error) begin
          fin       = 1'b1;
          rsp_done  = sel;
          rsp_error = sel;
          state_d   = ARB;
        end
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q   <= ARB;
      g_q       <= '0;
      beats_q   <= '0;
      issue_cnt <= '0;
      rsp_cnt   <= '0;
      addr_q    <= '0;
      size_q    <= '0;
      write_q   <= 1'b0;
      first_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        g_q       <= win_idx;
        beats_q   <= beats_in;
        issue_cnt <= beats_in;
        rsp_cnt   <= '0;
        addr_q    <= req_addr[int'(win_idx)*ADDR_W +: ADDR_W];
        size_q    <= req_size[int'(win_idx)*2 +: 2];
        write_q   <= req_write[win_idx];
        first_q   <= 1'b1;
      end
      if (step) begin
        issue_cnt <= issue_cnt - 5'd1;
        addr_q    <= addr_q + ADDR_W'(bytes_of(size_q));
        first_q   <= 1'b0;
      end
      if (count) rsp_cnt <= rsp_cnt + 5'd1;
    end
  end

endmodule

// File: doc/ahb_app_arbiter.md
# ahb_app_arbiter

Round-robin arbiter and burst sequencer that shares one AHB-Lite master's application port among `NUM_REQ` requesters. It accepts whole transfer commands (single or INCR burst, 1–16 beats) from requesters and drives the master's `opcode`/`addr`/`data_in`/`enable`/`busy` inputs beat by beat. It routes `data_out`/`data_valid`/`error` back to the granted requester. It sits between the application clients (UART bridge, DMA, CPU shim) and the AHB master.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8
- `ADDR_W`, 32: address width
- `DATA_W`, 32: data width
- `HCLK` in 1: clock
- `HRESETn` in 1: asynchronous active-low reset
- `req_valid` in NUM_REQ: command pending, held until `req_ack`
- `req_write` in NUM_REQ: 1 = write
- `req_size` in 2×NUM_REQ: size code; 0 = 1 B, 1 = 2 B, 2 = 4 B, 3 = 1 B (UART)
- `req_beats` in 5×NUM_REQ: burst length 1..16; 0 is treated as 1
- `req_addr` in ADDR_W×NUM_REQ: start address
- `req_wdata` in DATA_W×NUM_REQ: current write beat
- `req_ack` out NUM_REQ: one-cycle pulse; command captured
- `wdata_pop` out NUM_REQ: one-cycle pulse; write beat consumed, present next
- `rsp_rdata` out DATA_W: shared read data
- `rsp_valid` out NUM_REQ: read beat valid for the granted requester
- `rsp_done` out NUM_REQ: one-cycle pulse; command complete
- `rsp_error` out NUM_REQ: one-cycle pulse with `rsp_done` on error termination
- `m_opcode` out 5: {new_trans, incr, write, size[1:0]}
- `m_addr` out ADDR_W; `m_data_in` out DATA_W; `m_enable` out 1; `m_busy` out 1 (tied 0)
- `m_data_out` in DATA_W; `m_data_valid` in 1; `m_error` in 1; `m_wait` in 1

## Operation
- **States:** ARB, ISSUE, DRAIN.
- **ARB**
  - Outputs are zero.
  - If any `req_valid` is set, the winner is chosen combinationally by round-robin, starting from the index after the last grant.
  - The cycle a winner is chosen: pulse `req_ack[g]`, latch `g`, `beats`, `addr`, `size`, `write`, set `issue_cnt = beats`, `rsp_cnt = 0`, go to ISSUE.
- **ISSUE**
  - `m_enable` = 1, `m_addr` = `addr_q`, `m_data_in` = `req_wdata[g]`.
  - `m_opcode[4]` = 1 on the first beat only, else 0.
  - `m_opcode[3]` = (`beats` > 1); `m_opcode[2:0]` = {`write`, `size`}.
  - Each cycle with `m_wait` = 0: `issue_cnt` decrements, `addr_q` += bytes(size) with modulo 2^ADDR_W wrap, and `wdata_pop[g]` pulses if writing.
  - When `issue_cnt` == 1 and `m_wait` = 0: go to DRAIN.
- **DRAIN**
  - `m_enable` = 1, `m_opcode` = 0, so the master returns to IDLE after the last data phase.
  - `rsp_cnt` counts `m_data_valid` for reads, or cycles with `m_wait` = 0 for writes (ISSUE counts too).
  - When `rsp_cnt` == `beats`: pulse `rsp_done[g]`, go to ARB, advance the round-robin pointer past `g`.
- **Read data:** `rsp_valid[g]` = `m_data_valid` while ISSUE/DRAIN; `rsp_rdata` = `m_data_out`.
- **Error:** `m_error` = 1 in ISSUE or DRAIN pulses `rsp_done[g]` and `rsp_error[g]`, drops `m_enable` next cycle, and returns to ARB. Remaining beats are discarded.
- **Counter widths:** 5 bits. Beats = 16 must not overflow.

## Timing
- **Reset:** every output is 0, state = ARB, round-robin pointer = 0. Reset mid-burst aborts with no `rsp_done`.
- **Grant latency:** `req_valid` in cycle N, with the arbiter in ARB and no other winner, gives `req_ack` in N and `m_enable` = 1 with the first beat in N+1.
- **Re-arbitration:** earliest next `req_ack` is the cycle after `rsp_done`. There is no pipelining across commands.
- **Wait states:** `m_wait` = 1 freezes `issue_cnt`, `addr_q`, `m_opcode` and `m_data_in`; no `wdata_pop`.
- **Simultaneous `req_valid` in ARB:** exactly one `req_ack`.
- **`req_valid` deasserted before `req_ack`:** not allowed; behaviour is undefined.
- **`m_error` and last `m_data_valid` in the same cycle:** the error wins, and `rsp_valid` still pulses for that beat.

## Configuration
- **`ARB_FIXED_PRIO_EN`:**
  - Defined: fixed priority, lowest index wins, no round-robin pointer.
  - Undefined (default): round-robin as above.

## Structure
- **Shared package `ahb_app_pkg`:** state enum `arb_state_e`, opcode bit-position constants, size-code constants, `bytes_of(size)` function (also reused by the master's testbench).
- **Sub-module `rr_arbiter`:** NUM_REQ-wide request vector in, one-hot grant out, pointer update input. The `ARB_FIXED_PRIO_EN` selection lives there.

## Test plan
- **Single read:** req0 read, size 2, addr 0x100, beats 1, slave returns 0xDEADBEEF → `req_ack[0]` in the same cycle; `m_opcode` = 5'b10010; `rsp_valid[0]` with 0xDEADBEEF; `rsp_done[0]` once.
- **INCR write burst:** req1 write, 4 beats, size 2, addr 0x200 → `m_addr` 0x200/0x204/0x208/0x20C; opcode[4] set on the first beat only; 4 `wdata_pop[1]`; `rsp_done[1]` after the 4th data phase.
- **Contention:** req0..req3 all valid, 1-beat each → grant order 0,1,2,3,0. With `ARB_FIXED_PRIO_EN`, req0 is granted repeatedly while it stays valid.
- **Wait states:** 3 `m_wait` cycles during beat 2 of 4 → address and data held, no pop, total completion +3 cycles.
- **Error:** `m_error` on beat 2 of 8 → `rsp_error` and `rsp_done` pulse together, `m_enable` low the next cycle, next requester granted.
- **Edge cases:** `req_beats` = 0 runs as 1 beat; beats 16 starting at 0xFFFFFFF8 with size 2 wraps `m_addr` to 0x0; `HRESETn` low mid-burst → all outputs 0 with no `rsp_done`.
